// File: rtl/imm_gen_pipe.sv
// Purpose: pipelined RISC-V immediate generator; decodes format, sign-extends to XLEN, flags unknown opcodes, carries a tag.
// Latency: 1 cycle (accept at edge N, result on out_* after edge N); 1 instruction/cycle throughput.
// Backpressure: 2-entry buffer; in_ready = (count != 2) depends only on registered count, never on out_ready.
// Ports: clk/rst (async active-high), flush (sync drop-all), in_valid/in_ready/in_instr/in_tag (accept side),
//        out_valid/out_ready/out_imm/out_fmt/out_illegal/out_tag (head entry, all registered).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0] imm32;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  entry_t      dec;
  entry_t      head;
  entry_t      second;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // Every format's immediate fits in 32 bits with its sign at bit 31,
  // so decode at 32 bits and sign-extend once afterwards.
  always_comb begin
    imm32   = 32'd0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: begin
        imm32   = {in_instr[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      7'b1100011: begin
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0100011: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0011011: begin
        // OP-IMM-32 only exists on RV64.
        if (XLEN == 64) begin
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt = FMT_I;
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0110011: begin
        // R-type has no immediate; the I-field pattern is passed through for compatibility.
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    dec     = '0;
    dec.imm = XLEN'($signed(imm32));
    dec.fmt = dec_fmt;
    dec.ill = dec_ill;
    dec.tag = in_tag;
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // head always holds the oldest entry so the outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      head   <= '0;
      second <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head  <= dec;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= dec;
          end else if (push) begin
            second <= dec;
            count  <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head  <= second;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.ill;
  assign out_tag     = head.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic [7:0]  in_tag = 8'd0;
  logic        out_ready = 1'b0;

  logic        r32, v32, il32;
  logic [31:0] imm32;
  logic [2:0]  f32;
  logic [7:0]  t32;
  logic        r64, v64, il64;
  logic [63:0] imm64;
  logic [2:0]  f64;
  logic [7:0]  t64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(f32),
    .out_illegal(il32), .out_tag(t32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(f64),
    .out_illegal(il64), .out_tag(t64)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Reference decoder written field-by-field from the ISA encodings, at 64 bits.
  function automatic exp_t model(input logic [31:0] i, input bit x64, input logic [7:0] tag);
    exp_t e;
    e.imm = 64'd0; e.fmt = 3'd0; e.ill = 1'b0; e.tag = tag;
    case (i[6:0])
      7'h37, 7'h17: begin e.imm = {{32{i[31]}}, i[31:12], 12'h000}; e.fmt = 3'd4; end
      7'h6F: begin e.imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; e.fmt = 3'd5; end
      7'h63: begin e.imm = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; e.fmt = 3'd3; end
      7'h23: begin e.imm = {{52{i[31]}}, i[31:25], i[11:7]}; e.fmt = 3'd2; end
      7'h67, 7'h03, 7'h13: begin e.imm = {{52{i[31]}}, i[31:20]}; e.fmt = 3'd1; end
      7'h1B: begin
        if (x64) begin e.imm = {{52{i[31]}}, i[31:20]}; e.fmt = 3'd1; end
        else e.ill = 1'b1;
      end
      7'h33: e.imm = {{52{i[31]}}, i[31:20]};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One clock cycle: account for the handshakes the coming edge will perform,
  // then advance to 1 time unit after that edge.
  task automatic cycle();
    exp_t e;
    if (flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (v32 && out_ready) begin
        chk("pop32_expected", 64'(q32.size() > 0), 64'd1);
        if (q32.size() > 0) begin
          e = q32.pop_front();
          chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
          chk("fmt32", 64'(f32), 64'(e.fmt));
          chk("ill32", 64'(il32), 64'(e.ill));
          chk("tag32", 64'(t32), 64'(e.tag));
        end
      end
      if (v64 && out_ready) begin
        chk("pop64_expected", 64'(q64.size() > 0), 64'd1);
        if (q64.size() > 0) begin
          e = q64.pop_front();
          chk("imm64", imm64, e.imm);
          chk("fmt64", 64'(f64), 64'(e.fmt));
          chk("ill64", 64'(il64), 64'(e.ill));
          chk("tag64", 64'(t64), 64'(e.tag));
        end
      end
      if (in_valid && r32) q32.push_back(model(in_instr, 1'b0, in_tag));
      if (in_valid && r64) q64.push_back(model(in_instr, 1'b1, in_tag));
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one word into an empty pipe with out_ready low; leaves it at the head.
  task automatic send_one(input logic [31:0] instr, input logic [7:0] tag);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_tag    = tag;
    cycle();
    in_valid  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("drained32", 64'(q32.size()), 64'd0);
    chk("drained64", 64'(q64.size()), 64'd0);
  endtask

  logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h67, 7'h03, 7'h13, 7'h1B, 7'h33, 7'h7F};
  logic [31:0] rnd;

  initial begin
    // Reset state, visible while rst is high.
    #3;
    chk("rst_valid", 64'(v32), 64'd0);
    chk("rst_ready", 64'(r32), 64'd1);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_fmt", 64'(f64), 64'd0);
    chk("rst_ill", 64'(il32), 64'd0);
    chk("rst_tag", 64'(t64), 64'd0);
    in_valid = 1'b1; in_instr = 32'h12345037;
    @(posedge clk); #1;
    chk("push_in_rst_ignored", 64'(v32), 64'd0);
    in_valid = 1'b0;
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // Directed decodes.
    send_one(32'h12345037, 8'h11);
    chk("lui_valid", 64'(v32), 64'd1);
    chk("lui_imm32", 64'(imm32), 64'h12345000);
    chk("lui_fmt", 64'(f32), 64'd4);
    chk("lui_ill", 64'(il32), 64'd0);
    drain();
    send_one(32'h800000B7, 8'h12);
    chk("lui_imm64_neg", imm64, 64'hFFFFFFFF80000000);
    drain();
    send_one(32'hFE000EE3, 8'h13);
    chk("beq_imm32", 64'(imm32), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(f32), 64'd3);
    drain();
    send_one(32'hFE112C23, 8'h14);
    chk("sw_imm32", 64'(imm32), 64'hFFFFFFF8);
    chk("sw_fmt", 64'(f32), 64'd2);
    drain();
    send_one(32'h0000007F, 8'h15);
    chk("bad_imm", 64'(imm32), 64'd0);
    chk("bad_fmt", 64'(f32), 64'd0);
    chk("bad_ill", 64'(il32), 64'd1);
    drain();
    send_one(32'h0000001B, 8'h16);
    chk("opimm32_ill_x32", 64'(il32), 64'd1);
    chk("opimm32_ill_x64", 64'(il64), 64'd0);
    chk("opimm32_fmt_x64", 64'(f64), 64'd1);
    drain();

    // Back-pressure: tags 1,2,3 offered back-to-back, consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; in_tag = 8'd1; cycle();
    chk("bp_ready_after1", 64'(r32), 64'd1);
    in_instr  = 32'hFFF00093; in_tag = 8'd2; cycle();
    chk("bp_ready_after2", 64'(r32), 64'd0);
    in_instr  = 32'h00C0006F; in_tag = 8'd3; cycle();
    chk("bp_head_stable", 64'(t32), 64'd1);
    chk("bp_still_full", 64'(r64), 64'd0);
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    drain();

    // Flush with count=2 and a push offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr = 32'h00500113; in_tag = 8'd21; cycle();
    in_instr = 32'h00600113; in_tag = 8'd22; cycle();
    flush = 1'b1; in_instr = 32'h00700113; in_tag = 8'd23; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_valid", 64'(v32), 64'd0);
    chk("flush2_ready", 64'(r32), 64'd1);
    drain();

    // Flush with count=1, simultaneous push and pop.
    send_one(32'h00800113, 8'd31);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    in_instr = 32'h00900113; in_tag = 8'd32; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_valid", 64'(v64), 64'd0);
    chk("flush1_ready", 64'(r64), 64'd1);
    drain();

    // Async reset between edges with count=2.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'hABCDE037; in_tag = 8'd41; cycle();
    in_instr = 32'h8000006F; in_tag = 8'd42; cycle();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(v32), 64'd0);
    chk("arst_imm64", imm64, 64'd0);
    chk("arst_tag", 64'(t32), 64'd0);
    chk("arst_ready", 64'(r32), 64'd1);
    q32.delete(); q64.delete();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    drain();
    chk("arst_no_pop", 64'(v64), 64'd0);

    // Random traffic across all opcode classes.
    for (int n = 0; n < 200; n++) begin
      rnd       = $urandom();
      in_instr  = {rnd[31:7], ops[$urandom_range(0, 10)]};
      in_tag    = 8'(n);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
